// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe
//   Pipelined Kyber butterfly. Accepts one (a, b, zeta) triple per cycle and
//   returns (a', b') a fixed four cycles later. in_mode selects Cooley-Tukey
//   (forward NTT) or Gentleman-Sande (inverse NTT). Zeta arrives in Montgomery
//   form (zeta * 2^16 mod q), so a single Montgomery reduction of the product
//   yields operand * zeta mod q in the plain domain.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_mode               0 = CT, 1 = GS
//   in_a, in_b, in_zeta   12-bit operands, each in [0, q)
//   in_tag                opaque sideband, delivered with its result
//   out_valid / out_ready output handshake
//   out_a, out_b          12-bit results in [0, q)
//   out_tag               tag aligned with out_a / out_b
//
// A single global advance enable moves every stage together. Bubbles travel
// as cleared valid bits, so a stall anywhere simply freezes the whole pipe.

module ntt_butterfly_pipe #(
  parameter int TAG_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [11:0]          in_a,
  input  logic [11:0]          in_b,
  input  logic [11:0]          in_zeta,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [11:0]          out_a,
  output logic [11:0]          out_b,
  output logic [TAG_WIDTH-1:0] out_tag
);

  localparam int          LATENCY  = 4;
  localparam logic [12:0] KYBER_Q  = 13'd3329;
  // -q^-1 mod 2^16, so that t + m*q is an exact multiple of 2^16
  localparam logic [31:0] QINV_NEG = 32'd3327;

  function automatic logic [11:0] mod_add(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= KYBER_Q) s = s - KYBER_Q;
    return s[11:0];
  endfunction

  function automatic logic [11:0] mod_sub(input logic [11:0] x, input logic [11:0] y);
    logic [12:0] d;
    if (x < y) d = {1'b0, x} + KYBER_Q - {1'b0, y};
    else       d = {1'b0, x} - {1'b0, y};
    return d[11:0];
  endfunction

  // Returns t * 2^-16 mod q. The intermediate u is below 2q, so one
  // conditional subtraction finishes the reduction.
  function automatic logic [11:0] mont_reduce(input logic [23:0] t);
    logic [31:0] m_full;
    logic [15:0] m;
    logic [28:0] mq;
    logic [28:0] sum;
    logic [12:0] u;
    m_full = {16'b0, t[15:0]} * QINV_NEG;
    m      = m_full[15:0];
    mq     = {13'b0, m} * {16'b0, KYBER_Q};
    sum    = {5'b0, t} + mq;
    u      = sum[28:16];
    if (u >= KYBER_Q) u = u - KYBER_Q;
    return u[11:0];
  endfunction

  logic [LATENCY-1:0] vld;
  logic               adv;

  // stage 1: GS sum/difference already formed; s1_op is the multiplier operand
  logic                 s1_mode;
  logic [11:0]          s1_a;
  logic [11:0]          s1_op;
  logic [11:0]          s1_zeta;
  logic [TAG_WIDTH-1:0] s1_tag;

  // stage 2: raw product
  logic                 s2_mode;
  logic [11:0]          s2_a;
  logic [23:0]          s2_t;
  logic [TAG_WIDTH-1:0] s2_tag;

  // stage 3: reduced product r = operand * zeta mod q
  logic                 s3_mode;
  logic [11:0]          s3_a;
  logic [11:0]          s3_r;
  logic [TAG_WIDTH-1:0] s3_tag;

  assign adv       = !vld[LATENCY-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld[LATENCY-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      s1_mode <= 1'b0;
      s1_a    <= '0;
      s1_op   <= '0;
      s1_zeta <= '0;
      s1_tag  <= '0;
      s2_mode <= 1'b0;
      s2_a    <= '0;
      s2_t    <= '0;
      s2_tag  <= '0;
      s3_mode <= 1'b0;
      s3_a    <= '0;
      s3_r    <= '0;
      s3_tag  <= '0;
      out_a   <= '0;
      out_b   <= '0;
      out_tag <= '0;
    end else if (adv) begin
      vld     <= {vld[LATENCY-2:0], in_valid};

      s1_mode <= in_mode;
      s1_a    <= in_mode ? mod_add(in_a, in_b) : in_a;
      s1_op   <= in_mode ? mod_sub(in_a, in_b) : in_b;
      s1_zeta <= in_zeta;
      s1_tag  <= in_tag;

      s2_mode <= s1_mode;
      s2_a    <= s1_a;
      s2_t    <= {12'b0, s1_op} * {12'b0, s1_zeta};
      s2_tag  <= s1_tag;

      s3_mode <= s2_mode;
      s3_a    <= s2_a;
      s3_r    <= mont_reduce(s2_t);
      s3_tag  <= s2_tag;

      // GS: s3_a already holds (a+b) mod q
      out_a   <= s3_mode ? s3_a : mod_add(s3_a, s3_r);
      out_b   <= s3_mode ? s3_r : mod_sub(s3_a, s3_r);
      out_tag <= s3_tag;
    end
  end

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
module tb_ntt_butterfly_pipe;

  localparam int TW = 8;
  localparam int Q  = 3329;
  localparam int RINV = 169;   // 2^-16 mod q

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_mode = 1'b0;
  logic [11:0]   in_a = '0;
  logic [11:0]   in_b = '0;
  logic [11:0]   in_zeta = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [11:0]   out_a;
  logic [11:0]   out_b;
  logic [TW-1:0] out_tag;

  ntt_butterfly_pipe #(.TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_a(in_a), .in_b(in_b), .in_zeta(in_zeta), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  bit          held = 1'b0;
  logic [11:0] snap_a, snap_b;
  logic [TW-1:0] snap_tag;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
    end
  endtask

  // Butterfly computed directly from its mathematical definition.
  function automatic logic [31:0] model(input bit mode, input int a, input int b,
                                        input int zeta, input int tag);
    int zp, r, ea, eb;
    zp = (zeta * RINV) % Q;
    if (mode) begin
      ea = (a + b) % Q;
      r  = (((a - b + Q) % Q) * zp) % Q;
      eb = r;
    end else begin
      r  = (b * zp) % Q;
      ea = (a + r) % Q;
      eb = (a - r + Q) % Q;
    end
    return {tag[7:0], ea[11:0], eb[11:0]};
  endfunction

  // One clock of streamed stimulus with scoreboard and stall-hold checking.
  task automatic cycle(input bit iv, input bit m, input int a, input int b,
                       input int z, input int t, input bit ordy);
    logic [31:0] e;
    @(negedge clk);
    in_valid = iv; in_mode = m;
    in_a = a[11:0]; in_b = b[11:0]; in_zeta = z[11:0]; in_tag = t[TW-1:0];
    out_ready = ordy;
    #1;
    check("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) check("spurious_out", out_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        check("stream_a",   out_a,   e[23:12]);
        check("stream_b",   out_b,   e[11:0]);
        check("stream_tag", out_tag, e[31:24]);
      end
    end
    if (in_valid && in_ready) exp_q.push_back(model(m, a, b, z, t));
    held = out_valid && !out_ready;
    snap_a = out_a; snap_b = out_b; snap_tag = out_tag;
    @(posedge clk);
    #1;
    if (held) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_a",     out_a,     snap_a);
      check("hold_b",     out_b,     snap_b);
      check("hold_tag",   out_tag,   snap_tag);
    end
  endtask

  task automatic rand_cycle(input bit iv, input bit ordy);
    cycle(iv, 1'($urandom_range(0, 1)), $urandom_range(0, Q-1), $urandom_range(0, Q-1),
          $urandom_range(0, Q-1), $urandom_range(0, 255), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Single triple into an idle pipe; result must appear exactly 4 cycles later.
  task automatic directed(input bit m, input int a, input int b, input int z,
                          input int t, input int ea, input int eb);
    @(negedge clk);
    in_valid = 1'b1; in_mode = m; out_ready = 1'b1;
    in_a = a[11:0]; in_b = b[11:0]; in_zeta = z[11:0]; in_tag = t[TW-1:0];
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 4) check("dir_latency_early", out_valid, 1'b0);
      else begin
        check("dir_valid", out_valid, 1'b1);
        check("dir_a",     out_a,     ea);
        check("dir_b",     out_b,     eb);
        check("dir_tag",   out_tag,   t);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_a",     out_a,     0);
    check("rst_out_b",     out_b,     0);
    check("rst_out_tag",   out_tag,   0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    directed(1'b0, 1,    1,    2285, 8'h5A, 2,   0);
    directed(1'b0, 3000, 1000, 2285, 8'h11, 671, 2000);
    directed(1'b0, 0,    1,    2226, 8'h22, 17,  3312);
    directed(1'b1, 5,    10,   2285, 8'h33, 15,  3324);
    directed(1'b1, 3328, 3328, 2285, 8'h44, 3327, 0);

    // back-to-back stream, full throughput
    for (int i = 0; i < 256; i++) begin
      if (i >= 5) check("thru_valid", out_valid, 1'b1);
      rand_cycle(1'b1, 1'b1);
    end
    drain();

    // random valid/ready with backpressure
    for (int i = 0; i < 400; i++) rand_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();

    // reset with results in flight
    for (int i = 0; i < 6; i++) rand_cycle(1'b1, 1'b1);
    check("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_a",     out_a,     0);
    check("mid_rst_b",     out_b,     0);
    check("mid_rst_tag",   out_tag,   0);
    exp_q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 0, 0, 0, 0, 1'b1);
      check("post_rst_idle", out_valid, 1'b0);
    end

    directed(1'b0, 0, 1, 2226, 8'h77, 17, 3312);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
